alu_exec_ctrl: RTL and testbench

Multi-cycle sequencer for the shared barrel-shifter + ALU execute datapath. Accepts one decoded ARM data-processing instruction per handshake, fetches operands from the register file, drives the shifter/ALU control fields, and writes the result back. Owns the architectural NZCV flag register, so the datapath's flag latch is no longer needed. Sits between the decode stage and the register file.

---
 rtl/alu_exec_pkg.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute sequencer: state encodings,
// ARM data-processing opcodes and the compare/test opcode rule.
package alu_exec_pkg;

    localparam logic [2:0] IDLE_ENC  = 3'd0;
    localparam logic [2:0] RD_RN_ENC = 3'd1;
    localparam logic [2:0] RD_RM_ENC = 3'd2;
    localparam logic [2:0] RD_RS_ENC = 3'd3;
    localparam logic [2:0] EXEC_ENC  = 3'd4;
    localparam logic [2:0] WB_ENC    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE_ENC,
        S_RD_RN = RD_RN_ENC,
        S_RD_RM = RD_RM_ENC,
        S_RD_RS = RD_RS_ENC,
        S_EXEC  = EXEC_ENC,
        S_WB    = WB_ENC
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    // TST/TEQ/CMP/CMN only set flags and never write a destination register
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle sequencer for the shared shifter + ALU execute datapath.
// Reads operands from a combinational-read register file one per cycle,
// drives the datapath for a single EXEC cycle, then writes back.
// Owns the architectural NZCV flags.
module alu_exec_ctrl
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_op,
    input  logic [2:0]  in_shift_op,
    input  logic        in_s,
    input  logic        in_by_reg,
    input  logic [7:0]  in_shift_imm,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rm,
    input  logic [3:0]  in_rs,
    input  logic [3:0]  in_rd,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] dp_a,
    output logic [31:0] dp_shift_data,
    output logic [7:0]  dp_shift_num,
    output logic [2:0]  dp_shift_op,
    output logic [3:0]  dp_alu_op,
    output logic        dp_write_nzcv,
    output logic        dp_c_in,
    output logic        dp_v_in,
    input  logic [31:0] dp_f,
    input  logic [3:0]  dp_nzcv,
    input  logic        flag_we,
    input  logic [3:0]  flag_wdata,
    output logic [3:0]  nzcv,
    output logic        done
);

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_op;
    logic [2:0]  r_shift_op;
    logic        r_s;
    logic        r_by_reg;
    logic [3:0]  r_rn;
    logic [3:0]  r_rm;
    logic [3:0]  r_rs;
    logic [3:0]  r_rd;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [7:0]  r_shift_num;
    logic [31:0] r_result;
    logic [3:0]  r_nzcv;

    logic        w_accept;
    logic        w_skip_rn;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    // MOV/MVN ignore the first operand, so its read cycle is skipped
    assign w_skip_rn = (in_alu_op == OP_MOV) || (in_alu_op == OP_MVN);
    assign nzcv      = r_nzcv;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus register-file and datapath controls
    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        rf_raddr      = 4'd0;
        rf_we         = 1'b0;
        rf_waddr      = 4'd0;
        rf_wdata      = 32'd0;
        dp_a          = 32'd0;
        dp_shift_data = 32'd0;
        dp_shift_num  = 8'd0;
        dp_shift_op   = 3'd0;
        dp_alu_op     = 4'd0;
        dp_write_nzcv = 1'b0;
        dp_c_in       = 1'b0;
        dp_v_in       = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_skip_rn ? S_RD_RM : S_RD_RN;
                end
            end
            S_RD_RN: begin
                rf_raddr     = r_rn;
                w_state_next = S_RD_RM;
            end
            S_RD_RM: begin
                rf_raddr     = r_rm;
                w_state_next = r_by_reg ? S_RD_RS : S_EXEC;
            end
            S_RD_RS: begin
                rf_raddr     = r_rs;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                dp_a          = r_op_a;
                dp_shift_data = r_op_b;
                dp_shift_num  = r_shift_num;
                dp_shift_op   = r_shift_op;
                dp_alu_op     = r_op;
                dp_write_nzcv = r_s;
                dp_c_in       = r_nzcv[1];
                dp_v_in       = r_nzcv[0];
                w_state_next  = S_WB;
            end
            S_WB: begin
                rf_we        = !is_test_op(r_op);
                rf_waddr     = r_rd;
                rf_wdata     = r_result;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Instruction fields on accept, operands during the read cycles,
    // datapath result during EXEC; the result is held until overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 4'd0;
            r_shift_op  <= 3'd0;
            r_s         <= 1'b0;
            r_by_reg    <= 1'b0;
            r_rn        <= 4'd0;
            r_rm        <= 4'd0;
            r_rs        <= 4'd0;
            r_rd        <= 4'd0;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_shift_num <= 8'd0;
            r_result    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op        <= in_alu_op;
                r_shift_op  <= in_shift_op;
                r_s         <= in_s;
                r_by_reg    <= in_by_reg;
                r_rn        <= in_rn;
                r_rm        <= in_rm;
                r_rs        <= in_rs;
                r_rd        <= in_rd;
                // immediate amount stands unless RD_RS replaces it
                r_shift_num <= in_shift_imm;
            end
            if (r_state == S_RD_RN) begin
                r_op_a <= rf_rdata;
            end
            if (r_state == S_RD_RM) begin
                r_op_b <= rf_rdata;
            end
            if (r_state == S_RD_RS) begin
                r_shift_num <= rf_rdata[7:0];
            end
            if (r_state == S_EXEC) begin
                r_result <= dp_f;
            end
        end
    end

    // Flag register: an S=1 EXEC update takes priority over an external write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= 4'd0;
        end else if ((r_state == S_EXEC) && r_s) begin
            r_nzcv <= dp_nzcv;
        end else if (flag_we) begin
            r_nzcv <= flag_wdata;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl: register-file and shifter/ALU models around
// the sequencer, expected write-back/flags queued at issue time.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_op;
    logic [2:0]  in_shift_op;
    logic        in_s;
    logic        in_by_reg;
    logic [7:0]  in_shift_imm;
    logic [3:0]  in_rn, in_rm, in_rs, in_rd;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] dp_a, dp_shift_data;
    logic [7:0]  dp_shift_num;
    logic [2:0]  dp_shift_op;
    logic [3:0]  dp_alu_op;
    logic        dp_write_nzcv, dp_c_in, dp_v_in;
    logic [31:0] dp_f;
    logic [3:0]  dp_nzcv;
    logic        flag_we;
    logic [3:0]  flag_wdata;
    logic [3:0]  nzcv;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;
    logic [3:0] model_nzcv = 4'd0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_shift_op(in_shift_op), .in_s(in_s),
        .in_by_reg(in_by_reg), .in_shift_imm(in_shift_imm),
        .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs), .in_rd(in_rd),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dp_a(dp_a), .dp_shift_data(dp_shift_data), .dp_shift_num(dp_shift_num),
        .dp_shift_op(dp_shift_op), .dp_alu_op(dp_alu_op),
        .dp_write_nzcv(dp_write_nzcv), .dp_c_in(dp_c_in), .dp_v_in(dp_v_in),
        .dp_f(dp_f), .dp_nzcv(dp_nzcv), .flag_we(flag_we), .flag_wdata(flag_wdata),
        .nzcv(nzcv), .done(done)
    );

    // Barrel shifter model: 0 = LSL, 1 = LSR, anything else passes through
    function automatic logic [31:0] shf(input logic [31:0] d, input logic [7:0] n,
                                        input logic [2:0] op);
        case (op)
            3'd0:    return (n >= 8'd32) ? 32'd0 : (d << n);
            3'd1:    return (n >= 8'd32) ? 32'd0 : (d >> n);
            default: return d;
        endcase
    endfunction

    // ARM ALU model returning {N,Z,C,V,result}
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic c,
                                            input logic v);
        logic [31:0] x, y, f;
        logic        ci, arith, co, vo;
        logic [32:0] sum;
        x = a; y = b; ci = 1'b0; arith = 1'b0; f = 32'd0;
        case (op)
            4'd0, 4'd8: f = a & b;
            4'd1, 4'd9: f = a ^ b;
            4'd12:      f = a | b;
            4'd13:      f = b;
            4'd14:      f = a & ~b;
            4'd15:      f = ~b;
            4'd2, 4'd10: begin arith = 1'b1; x = a; y = ~b; ci = 1'b1; end
            4'd3:        begin arith = 1'b1; x = b; y = ~a; ci = 1'b1; end
            4'd4, 4'd11: begin arith = 1'b1; x = a; y = b;  ci = 1'b0; end
            4'd5:        begin arith = 1'b1; x = a; y = b;  ci = c;    end
            4'd6:        begin arith = 1'b1; x = a; y = ~b; ci = c;    end
            default:     begin arith = 1'b1; x = b; y = ~a; ci = c;    end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (arith) begin
            f  = sum[31:0];
            co = sum[32];
            vo = (x[31] == y[31]) && (f[31] != x[31]);
        end else begin
            co = c;
            vo = v;
        end
        return {f[31], (f == 32'd0), co, vo, f};
    endfunction

    // Datapath and register-file models
    logic [35:0] dp_res;
    assign dp_res  = alu_ref(dp_alu_op, dp_a, shf(dp_shift_data, dp_shift_num, dp_shift_op),
                             dp_c_in, dp_v_in);
    assign dp_f    = dp_res[31:0];
    assign dp_nzcv = dp_res[35:32];

    logic [31:0] rf_mem [16];
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  nzcv;
        int          lat;
        logic        chk_a;
        logic [31:0] a;
        logic [31:0] sd;
        logic [7:0]  sn;
        logic        wn;
    } exp_t;
    exp_t sb[$];

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_alu_op = 4'd0; in_shift_op = 3'd0;
        in_s = 1'b0; in_by_reg = 1'b0; in_shift_imm = 8'd0;
        in_rn = 4'd0; in_rm = 4'd0; in_rs = 4'd0; in_rd = 4'd0;
        flag_we = 1'b0; flag_wdata = 4'd0;
        repeat (3) @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (rf_we !== 1'b0) begin n_miss++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (nzcv !== 4'd0) begin n_miss++; $display("FAIL reset_nzcv: got %b want 0000", nzcv); end
        n_vec++; if ({dp_a, dp_shift_data, dp_shift_num, dp_shift_op, dp_alu_op, dp_write_nzcv, dp_c_in, dp_v_in} !== 82'd0) begin
            n_miss++; $display("FAIL reset_dp: got a=%h sd=%h sn=%h nonzero, want all 0", dp_a, dp_shift_data, dp_shift_num); end
        n_vec++; if (rf_raddr !== 4'd0) begin n_miss++; $display("FAIL reset_raddr: got %h want 0", rf_raddr); end
        rst_n = 1'b1;
        model_nzcv = 4'd0;
    endtask

    // Issue one instruction, queue its expected effect, wait for retirement and compare
    task automatic run_instr(input string name, input logic [3:0] op, input logic [2:0] sop,
                             input logic s, input logic by_reg, input logic [7:0] imm,
                             input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                             input logic [3:0] rd, input logic flag_in_exec,
                             input logic [3:0] flag_val);
        exp_t        e, g;
        logic [7:0]  amt;
        logic [35:0] r;
        logic [31:0] cap_a, cap_sd;
        logic [7:0]  cap_sn;
        logic        cap_wn, early_we, seen;
        logic        got_we;
        logic [3:0]  got_waddr, got_nzcv;
        logic [31:0] got_wdata;
        int          got_lat;
        amt     = by_reg ? rf_mem[rs][7:0] : imm;
        r       = alu_ref(op, rf_mem[rn], shf(rf_mem[rm], amt, sop), model_nzcv[1], model_nzcv[0]);
        e.we    = !(op >= 4'd8 && op <= 4'd11);
        e.waddr = rd;
        e.wdata = r[31:0];
        e.nzcv  = s ? r[35:32] : (flag_in_exec ? flag_val : model_nzcv);
        e.lat   = ((op == 4'd13 || op == 4'd15) ? 3 : 4) + (by_reg ? 1 : 0);
        e.chk_a = !(op == 4'd13 || op == 4'd15);
        e.a     = rf_mem[rn];
        e.sd    = rf_mem[rm];
        e.sn    = amt;
        e.wn    = s;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL %s_ready: got %b want 1", name, in_ready); end
        in_valid = 1'b1; in_alu_op = op; in_shift_op = sop; in_s = s; in_by_reg = by_reg;
        in_shift_imm = imm; in_rn = rn; in_rm = rm; in_rs = rs; in_rd = rd;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cap_a = '0; cap_sd = '0; cap_sn = '0; cap_wn = 1'b0; early_we = 1'b0; seen = 1'b0;
        got_we = 1'b0; got_waddr = '0; got_wdata = '0; got_nzcv = '0; got_lat = 0;
        for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == e.lat - 1) begin
                cap_a = dp_a; cap_sd = dp_shift_data; cap_sn = dp_shift_num; cap_wn = dp_write_nzcv;
                if (flag_in_exec) begin flag_we = 1'b1; flag_wdata = flag_val; end
            end
            if (cyc == e.lat) flag_we = 1'b0;
            if (done) begin
                seen = 1'b1; got_lat = cyc; got_we = rf_we; got_waddr = rf_waddr;
                got_wdata = rf_wdata; got_nzcv = nzcv;
            end else if (rf_we) begin
                early_we = 1'b1;
            end
        end
        flag_we = 1'b0;
        g = sb.pop_front();
        n_vec++; if (!seen) begin n_miss++; $display("FAIL %s_timeout: no done within 12 cycles", name); end
        n_vec++; if (got_lat != g.lat) begin n_miss++; $display("FAIL %s_latency: got %0d want %0d", name, got_lat, g.lat); end
        n_vec++; if (early_we !== 1'b0) begin n_miss++; $display("FAIL %s_early_we: got 1 want 0", name); end
        n_vec++; if (got_we !== g.we) begin n_miss++; $display("FAIL %s_rf_we: got %b want %b", name, got_we, g.we); end
        if (g.we) begin
            n_vec++; if (got_waddr !== g.waddr) begin n_miss++; $display("FAIL %s_waddr: got %h want %h", name, got_waddr, g.waddr); end
            n_vec++; if (got_wdata !== g.wdata) begin n_miss++; $display("FAIL %s_wdata: got %h want %h", name, got_wdata, g.wdata); end
        end
        n_vec++; if (got_nzcv !== g.nzcv) begin n_miss++; $display("FAIL %s_nzcv: got %b want %b", name, got_nzcv, g.nzcv); end
        if (g.chk_a) begin
            n_vec++; if (cap_a !== g.a) begin n_miss++; $display("FAIL %s_dp_a: got %h want %h", name, cap_a, g.a); end
        end
        n_vec++; if (cap_sd !== g.sd) begin n_miss++; $display("FAIL %s_dp_sd: got %h want %h", name, cap_sd, g.sd); end
        n_vec++; if (cap_sn !== g.sn) begin n_miss++; $display("FAIL %s_dp_sn: got %h want %h", name, cap_sn, g.sn); end
        n_vec++; if (cap_wn !== g.wn) begin n_miss++; $display("FAIL %s_dp_wnzcv: got %b want %b", name, cap_wn, g.wn); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++; $display("FAIL %s_after: got done=%b ready=%b want done=0 ready=1", name, done, in_ready); end
        model_nzcv = g.nzcv;
        $display("%s: op=%0d rd=%0d wdata=%h nzcv=%b lat=%0d", name, op, rd, got_wdata, got_nzcv, got_lat);
    endtask

    task automatic test_add();
        rf_mem[0] = 32'd5; rf_mem[1] = 32'd7;
        run_instr("add", 4'd4, 3'd0, 1'b1, 1'b0, 8'd0, 4'd0, 4'd1, 4'd0, 4'd2, 1'b0, 4'd0);
    endtask

    task automatic test_cmp();
        rf_mem[3] = 32'd9; rf_mem[4] = 32'd9;
        run_instr("cmp", 4'd10, 3'd0, 1'b1, 1'b0, 8'd0, 4'd3, 4'd4, 4'd0, 4'd5, 1'b0, 4'd0);
    endtask

    task automatic test_mov_by_reg();
        rf_mem[5] = 32'h104; rf_mem[2] = 32'd1;
        run_instr("mov_lsl_rs", 4'd13, 3'd0, 1'b0, 1'b1, 8'd0, 4'd0, 4'd2, 4'd5, 4'd1, 1'b0, 4'd0);
        run_instr("mvn_imm", 4'd15, 3'd1, 1'b1, 1'b0, 8'd4, 4'd0, 4'd5, 4'd0, 4'd6, 1'b0, 4'd0);
    endtask

    task automatic test_flag_write();
        rf_mem[6] = 32'd5; rf_mem[7] = 32'd3;
        run_instr("subs_flag_collide", 4'd2, 3'd0, 1'b1, 1'b0, 8'd0, 4'd6, 4'd7, 4'd0, 4'd8, 1'b1, 4'hF);
        @(negedge clk);
        flag_we = 1'b1; flag_wdata = 4'hF;
        @(negedge clk);
        flag_we = 1'b0;
        n_vec++; if (nzcv !== 4'hF) begin n_miss++; $display("FAIL flag_idle: got %b want 1111", nzcv); end
        model_nzcv = 4'hF;
        $display("flag_idle: nzcv=%b", nzcv);
    endtask

    task automatic test_reset_mid();
        logic bad;
        rf_mem[9] = 32'hDEAD_0000;
        @(negedge clk);
        in_valid = 1'b1; in_alu_op = 4'd4; in_s = 1'b1; in_by_reg = 1'b0; in_shift_imm = 8'd0;
        in_rn = 4'd0; in_rm = 4'd1; in_rd = 4'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);   // RD_RN
        @(negedge clk);   // RD_RM
        rst_n = 1'b0;
        #1;
        n_vec++; if (nzcv !== 4'd0) begin n_miss++; $display("FAIL rstmid_nzcv: got %b want 0000", nzcv); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rstmid_idle: got ready=%b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rf_we || done) bad = 1'b1;
        end
        n_vec++; if (bad !== 1'b0) begin n_miss++; $display("FAIL rstmid_no_wb: got rf_we/done activity want none"); end
        n_vec++; if (rf_mem[9] !== 32'hDEAD_0000) begin n_miss++; $display("FAIL rstmid_r9: got %h want dead0000", rf_mem[9]); end
        model_nzcv = 4'd0;
        $display("reset_mid: nzcv=%b ready=%b", nzcv, in_ready);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [10];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
        run_instr("add_r15", 4'd4, 3'd0, 1'b1, 1'b0, 8'd1, 4'd3, 4'd4, 4'd0, 4'd15, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            run_instr("b2b", ops[$urandom_range(0, 9)], 3'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 40)), 4'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom), 1'b0, 4'd0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_mov_by_reg();
        test_flag_write();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
